// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard control block.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    // Forward source for one Execute operand. Memory stage wins over
    // Writeback because it holds the younger result. x0 is never forwarded.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] rs_e,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs_e))
            return FWD_M;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs_e))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for the hazard performance statistics.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, holding at all-ones once reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != {WIDTH{1'b1}}))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard control for the 5-stage pipeline: operand forwarding, load-use
// and memory-wait stalls, branch flushes, and performance counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] RedirectCount
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    mem_state_t  state_reg;
    mem_state_t  state_next;
    logic [15:0] wait_cnt_reg;
    logic        mem_err_reg;
    logic        timeout;
    logic        mem_stall;
    logic        lw_stall;

    // Operand A uses Rs1E, operand B uses Rs2E; identical selection logic.
    logic [4:0] rs_e [2];
    fwd_sel_t   fwd  [2];

    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd[gi] = fwd_select(rs_e[gi], RdM, RegWriteM, RdW, RegWriteW);
        end
    endgenerate

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];

    // Memory wait FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= MEM_IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic: enter WAIT on an unacknowledged access, leave on
    // ready or when the wait budget is exhausted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MEM_IDLE: if (MemReqM && !MemReadyM) state_next = MEM_WAIT;
            MEM_WAIT: if (MemReadyM || timeout)  state_next = MEM_IDLE;
            default:  state_next = MEM_IDLE;
        endcase
    end

    // Stall/flush outputs. A memory stall freezes everything and defers any
    // flush; the frozen E stage keeps PCSrcE asserted until it can act.
    always_comb begin
        timeout   = (state_reg == MEM_WAIT) && (wait_cnt_reg == TIMEOUT_LAST);
        mem_stall = MemReqM && !MemReadyM && !timeout;
        lw_stall  = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
        StallF    = lw_stall || mem_stall;
        StallD    = lw_stall || mem_stall;
        StallE    = mem_stall;
        StallM    = mem_stall;
        StallW    = mem_stall;
        FlushD    = PCSrcE && !mem_stall;
        FlushE    = (lw_stall || PCSrcE) && !mem_stall;
    end

    // Wait-cycle counter: cleared while idle, counts every WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt_reg <= 16'd0;
        else if (state_reg == MEM_IDLE)
            wait_cnt_reg <= 16'd0;
        else
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
    end

    // Sticky error flag; only reset clears a memory timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_err_reg <= 1'b0;
        else if (timeout)
            mem_err_reg <= 1'b1;
    end

    assign MemErr = mem_err_reg;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (StallF),
        .count (StallCycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (FlushD),
        .count (RedirectCount)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (MEM_TIMEOUT=4, CNT_W=8).
module tb_hazard_unit;
    import hazard_pkg::*;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE, MemReqM, MemReadyM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM, StallW;
    logic             FlushD, FlushE, MemErr;
    logic [CNT_W-1:0] StallCycles, RedirectCount;

    int checks = 0;
    int errors = 0;

    hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Rs1D          (Rs1D),
        .Rs2D          (Rs2D),
        .Rs1E          (Rs1E),
        .Rs2E          (Rs2E),
        .RdE           (RdE),
        .RdM           (RdM),
        .RdW           (RdW),
        .RegWriteM     (RegWriteM),
        .RegWriteW     (RegWriteW),
        .ResultSrcE    (ResultSrcE),
        .PCSrcE        (PCSrcE),
        .MemReqM       (MemReqM),
        .MemReadyM     (MemReadyM),
        .ForwardAE     (ForwardAE),
        .ForwardBE     (ForwardBE),
        .StallF        (StallF),
        .StallD        (StallD),
        .StallE        (StallE),
        .StallM        (StallM),
        .StallW        (StallW),
        .FlushD        (FlushD),
        .FlushE        (FlushE),
        .MemErr        (MemErr),
        .StallCycles   (StallCycles),
        .RedirectCount (RedirectCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-14s observed %0h expected %0h", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0;
        PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic check_stall_all(input string tag, input logic exp);
        check({tag, "_F"}, StallF, exp);
        check({tag, "_E"}, StallE, exp);
        check({tag, "_M"}, StallM, exp);
        check({tag, "_W"}, StallW, exp);
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #1;
        // Reset state with all inputs low
        check("rst_fwdA", ForwardAE, 2'b00);
        check("rst_fwdB", ForwardBE, 2'b00);
        check("rst_stallF", StallF, 1'b0);
        check("rst_stallE", StallE, 1'b0);
        check("rst_flushD", FlushD, 1'b0);
        check("rst_flushE", FlushE, 1'b0);
        check("rst_memerr", MemErr, 1'b0);
        check("rst_stallcnt", StallCycles, 0);
        check("rst_redircnt", RedirectCount, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Forwarding priority and x0 handling
        RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1; #1;
        check("fwdA_M", ForwardAE, 2'b10);
        RegWriteM = 0; #1;
        check("fwdA_W", ForwardAE, 2'b01);
        Rs1E = 0; RdM = 0; RegWriteM = 1; #1;
        check("fwdA_x0", ForwardAE, 2'b00);
        Rs2E = 5; RdM = 9; #1;
        check("fwdB_W", ForwardBE, 2'b01);
        RdM = 5; #1;
        check("fwdB_M", ForwardBE, 2'b10);
        clear_inputs(); #1;
        check("fwd_none", ForwardBE, 2'b00);

        // Load-use stall
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; #1;
        check("lu_stallF", StallF, 1'b1);
        check("lu_stallD", StallD, 1'b1);
        check("lu_flushE", FlushE, 1'b1);
        check("lu_flushD", FlushD, 1'b0);
        check("lu_stallE", StallE, 1'b0);
        check("lu_fwdB", ForwardBE, 2'b00);
        tick();
        check("lu_cnt1", StallCycles, 1);
        tick();
        check("lu_cnt2", StallCycles, 2);
        clear_inputs();
        tick();
        check("lu_cnt_hold", StallCycles, 2);

        // Taken branch
        PCSrcE = 1; #1;
        check("br_flushD", FlushD, 1'b1);
        check("br_flushE", FlushE, 1'b1);
        check("br_stallF", StallF, 1'b0);
        tick();
        check("br_redir1", RedirectCount, 1);
        PCSrcE = 0; #1;
        check("br_flushD_off", FlushD, 1'b0);
        tick();
        check("br_redir_hold", RedirectCount, 1);

        // Memory wait: three stalled cycles, then ready
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_stall_all($sformatf("mw_stall%0d", i), 1'b1);
            tick();
        end
        check("mw_state", dut.state_reg, MEM_WAIT);
        MemReadyM = 1; #1;
        check_stall_all("mw_ready", 1'b0);
        check("mw_memerr", MemErr, 1'b0);
        tick();
        check("mw_state_idle", dut.state_reg, MEM_IDLE);
        clear_inputs(); #1;
        check("mw_stallcnt", StallCycles, 5);

        // Branch held during memory wait: flush deferred to ready cycle
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("bmw_flushD%0d", i), FlushD, 1'b0);
            check($sformatf("bmw_flushE%0d", i), FlushE, 1'b0);
            tick();
        end
        MemReadyM = 1; #1;
        check("bmw_flushD_rdy", FlushD, 1'b1);
        check("bmw_flushE_rdy", FlushE, 1'b1);
        tick();
        check("bmw_redir", RedirectCount, 2);
        check("bmw_stallcnt", StallCycles, 7);
        clear_inputs();

        // Timeout: four stalled cycles, released on the fourth WAIT cycle
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("to_stall%0d", i), StallF, 1'b1);
            tick();
        end
        check_stall_all("to_release", 1'b0);
        check("to_memerr_pre", MemErr, 1'b0);
        tick();
        MemReqM = 0; #1;
        check("to_memerr", MemErr, 1'b1);
        check("to_state", dut.state_reg, MEM_IDLE);
        check("to_stallcnt", StallCycles, 11);
        tick();
        tick();
        check("to_memerr_sticky", MemErr, 1'b1);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_memerr", MemErr, 1'b0);
        check("arst_stallcnt", StallCycles, 0);
        check("arst_redircnt", RedirectCount, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Load-use with branch, held until both counters saturate
        ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; PCSrcE = 1; #1;
        check("lubr_stallF", StallF, 1'b1);
        check("lubr_flushD", FlushD, 1'b1);
        check("lubr_flushE", FlushE, 1'b1);
        repeat (300) tick();
        check("sat_stallcnt", StallCycles, 8'hFF);
        check("sat_redircnt", RedirectCount, 8'hFF);

        // Load into x0 never stalls
        RdE = 0; Rs1D = 0; #1;
        check("lu_x0_stallD", StallD, 1'b0);

        // Zero-wait access never stalls
        clear_inputs();
        MemReqM = 1; MemReadyM = 1; #1;
        check("zw_stallE", StallE, 1'b0);
        tick();
        check("zw_state", dut.state_reg, MEM_IDLE);
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
